// File: rtl/pcm_byte_serializer_if.sv
// Byte-stream valid/ready bundle between the PCM serializer and the WAV capture.
// The master drives data and framing; the slave drives ready.
interface pcm_byte_serializer_if;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       byte_last;

    modport master (
        output byte_valid,
        output byte_data,
        output byte_last,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        input  byte_last,
        output byte_ready
    );
endinterface

// File: rtl/pcm_byte_serializer.sv
// PCM frame to little-endian interleaved byte stream, with a frame FIFO
// that drops (and counts) frames instead of stalling the sample source.
module pcm_byte_serializer #(
    parameter int unsigned SAMPLE_BITS = 16,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sample_stb,
    input  logic [CHANNELS*SAMPLE_BITS-1:0] sample_data,
    pcm_byte_serializer_if.master           byte_if,
    output logic [31:0]                     frame_cnt,
    output logic [15:0]                     drop_cnt
);

    localparam int unsigned FRAME_BITS  = CHANNELS * SAMPLE_BITS;
    localparam int unsigned FRAME_BYTES = FRAME_BITS / 8;
    localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IDX_W       =
        (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

    // WAV stores 8-bit PCM as offset binary, wider PCM as signed.
    localparam logic [7:0] BYTE_XOR =
        (SAMPLE_BITS == 8) ? 8'h80 : 8'h00;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t state_q, state_d;

    logic [FRAME_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic empty;
    logic full;
    logic xfer;
    logic last_idx;
    logic pop;
    logic push;
    logic drop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_FULL);
    assign xfer     = (state_q == SEND) && byte_if.byte_ready;
    assign last_idx = (idx_q == IDX_LAST);

    // A pop on this edge frees a slot for a simultaneous push.
    assign push = sample_stb && (!full || pop);
    assign drop = sample_stb && !push;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer && last_idx) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            idx_d   = '0;
        end else if (xfer) begin
            shift_d = shift_q >> 8;
            idx_d   = idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (xfer && last_idx) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
        end
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            shift_q     <= '0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_data;
        end
    end

    assign byte_if.byte_valid = (state_q == SEND);
    assign byte_if.byte_last  = (state_q == SEND) && last_idx;
    assign byte_if.byte_data  =
        (state_q == SEND) ? (shift_q[7:0] ^ BYTE_XOR) : 8'h00;

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pcm_byte_serializer.sv
// Scoreboard bench: stimulus queues expected bytes, monitors pop and compare.
// Covers a stereo 16-bit instance and a mono 8-bit instance.
module tb_pcm_byte_serializer;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        stb;
    logic [31:0] sdata;
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic        stb8;
    logic [7:0]  sdata8;
    logic [31:0] frame_cnt8;
    logic [15:0] drop_cnt8;

    int tests = 0;
    int fails = 0;

    exp_t q16[$];
    exp_t q8[$];

    pcm_byte_serializer_if bif ();
    pcm_byte_serializer_if bif8 ();

    pcm_byte_serializer #(
        .SAMPLE_BITS(16),
        .CHANNELS   (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_stb (stb),
        .sample_data(sdata),
        .byte_if    (bif.master),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt)
    );

    pcm_byte_serializer #(
        .SAMPLE_BITS(8),
        .CHANNELS   (1),
        .FIFO_DEPTH (4)
    ) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_stb (stb8),
        .sample_data(sdata8),
        .byte_if    (bif8.master),
        .frame_cnt  (frame_cnt8),
        .drop_cnt   (drop_cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bif.byte_valid && bif.byte_ready) begin
            if (q16.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL s16_extra: got %0h want none",
                         bif.byte_data);
            end else begin
                e = q16.pop_front();
                check("s16_byte", {23'd0, bif.byte_data, bif.byte_last},
                      {23'd0, e.data, e.last});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bif8.byte_valid && bif8.byte_ready) begin
            if (q8.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL m8_extra: got %0h want none",
                         bif8.byte_data);
            end else begin
                e = q8.pop_front();
                check("m8_byte", {23'd0, bif8.byte_data, bif8.byte_last},
                      {23'd0, e.data, e.last});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp16(input logic [7:0] b, input logic l);
        exp_t e;
        e.data = b;
        e.last = l;
        q16.push_back(e);
    endtask

    task automatic push16(input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            exp16(d[8*i +: 8], (i == 3));
        end
    endtask

    task automatic strobe16(input logic [31:0] d, input logic keep);
        stb   = 1'b1;
        sdata = d;
        if (keep) push16(d);
        tick();
        stb = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((q16.size() != 0 || bif.byte_valid) && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (q16.size() != 0 || bif.byte_valid) begin
            fails++;
            $display("FAIL %s_timeout: got %0d bytes pending want 0",
                     name, q16.size());
        end
    endtask

    initial begin
        exp_t e8;
        logic r;
        logic [31:0] fr [5];

        rst_n            = 1'b0;
        stb              = 1'b0;
        sdata            = '0;
        stb8             = 1'b0;
        sdata8           = '0;
        bif.byte_ready   = 1'b0;
        bif8.byte_ready  = 1'b1;
        fr[0] = 32'h0000_0001;
        fr[1] = 32'hA1B2_C3D4;
        fr[2] = 32'h7FFF_8000;
        fr[3] = 32'hDEAD_BEEF;
        fr[4] = 32'h0102_0304;

        repeat (3) tick();
        check("rst_valid", {31'd0, bif.byte_valid}, 32'd0);
        check("rst_data", {24'd0, bif.byte_data}, 32'd0);
        check("rst_last", {31'd0, bif.byte_last}, 32'd0);
        check("rst_frame", frame_cnt, 32'd0);
        check("rst_drop", {16'd0, drop_cnt}, 32'd0);
        check("rst_data8", {24'd0, bif8.byte_data}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Stereo 16-bit single frame with ready high.
        bif.byte_ready = 1'b1;
        exp16(8'h34, 1'b0);
        exp16(8'h12, 1'b0);
        exp16(8'h01, 1'b0);
        exp16(8'h80, 1'b1);
        stb   = 1'b1;
        sdata = 32'h8001_1234;
        tick();
        stb = 1'b0;
        @(negedge clk);
        check("lat_e0_valid", {31'd0, bif.byte_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("st_valid", {31'd0, bif.byte_valid}, 32'd1);
        end
        @(negedge clk);
        check("st_idle", {31'd0, bif.byte_valid}, 32'd0);
        check("st_frame", frame_cnt, 32'd1);
        check("st_empty", q16.size(), 32'd0);
        tick();

        // Mono 8-bit: offset-binary conversion.
        e8.last = 1'b1;
        e8.data = 8'h80;
        q8.push_back(e8);
        e8.data = 8'hFF;
        q8.push_back(e8);
        e8.data = 8'h00;
        q8.push_back(e8);
        stb8 = 1'b1;
        sdata8 = 8'h00;
        tick();
        sdata8 = 8'h7F;
        tick();
        sdata8 = 8'h80;
        tick();
        stb8 = 1'b0;
        repeat (6) tick();
        check("m8_empty", q8.size(), 32'd0);
        check("m8_frame", frame_cnt8, 32'd3);
        check("m8_drop", {16'd0, drop_cnt8}, 32'd0);

        // Back-pressure: 7 strobes, 5 retained, 2 dropped.
        bif.byte_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            strobe16(32'h1111_0000 + 32'(i * 32'h0101_0101), (i < 5));
        end
        tick();
        check("bp_drop", {16'd0, drop_cnt}, 32'd2);
        check("bp_frame_hold", frame_cnt, 32'd1);
        check("bp_hold_valid", {31'd0, bif.byte_valid}, 32'd1);
        check("bp_hold_data", {24'd0, bif.byte_data}, 32'h00);
        bif.byte_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_nogap", {31'd0, bif.byte_valid}, 32'd1);
        end
        @(negedge clk);
        check("bp_idle", {31'd0, bif.byte_valid}, 32'd0);
        check("bp_frame", frame_cnt, 32'd6);
        check("bp_empty", q16.size(), 32'd0);
        tick();

        // Drop counter saturation.
        bif.byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            strobe16(fr[i], 1'b1);
        end
        force dut.drop_cnt_q = 16'hFFFF;
        tick();
        release dut.drop_cnt_q;
        strobe16(32'h5555_AAAA, 1'b0);
        tick();
        check("sat_drop", {16'd0, drop_cnt}, 32'h0000_FFFF);
        bif.byte_ready = 1'b1;
        drain("sat", 60);
        check("sat_frame", frame_cnt, 32'd11);

        // Frame counter wrap.
        force dut.frame_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.frame_cnt_q;
        strobe16(32'h1357_9BDF, 1'b1);
        drain("wrap", 30);
        tick();
        check("wrap_frame", frame_cnt, 32'd0);

        // Asynchronous reset in the middle of a frame.
        bif.byte_ready = 1'b0;
        strobe16(32'hFFFF_FFFF, 1'b0);
        repeat (2) tick();
        check("mid_valid_pre", {31'd0, bif.byte_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_valid", {31'd0, bif.byte_valid}, 32'd0);
        check("mid_data", {24'd0, bif.byte_data}, 32'd0);
        check("mid_last", {31'd0, bif.byte_last}, 32'd0);
        check("mid_frame", frame_cnt, 32'd0);
        check("mid_drop", {16'd0, drop_cnt}, 32'd0);
        check("mid_frame8", frame_cnt8, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        bif.byte_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_idle", {31'd0, bif.byte_valid}, 32'd0);
        end
        tick();

        // Random data, exactly one ready cycle in every pair.
        r = 1'b0;
        for (int f = 0; f < 1000; f++) begin
            for (int c = 0; c < 8; c++) begin
                if (c % 2 == 0) begin
                    r = 1'($urandom_range(0, 1));
                    bif.byte_ready = r;
                end else begin
                    bif.byte_ready = ~r;
                end
                if (c == 0) begin
                    stb   = 1'b1;
                    sdata = $urandom;
                    push16(sdata);
                end
                tick();
                stb = 1'b0;
            end
        end
        bif.byte_ready = 1'b1;
        drain("rnd", 200);
        tick();
        check("rnd_drop", {16'd0, drop_cnt}, 32'd0);
        check("rnd_frame", frame_cnt, 32'd1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
